// File: rtl/wbu_rxuart.sv
// 8N1 serial receiver: two-flop synchronized input, single mid-bit sample per bit,
// byte strobe on a good stop bit, framing-error strobe and line-break level otherwise.
module wbu_rxuart #(
    parameter int CLOCKS_PER_BAUD = 25
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_uart_rx,
    output logic       o_wr,
    output logic [7:0] o_data,
    output logic       o_frame_err,
    output logic       o_break,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    localparam logic [23:0] HALF_LOAD = 24'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [23:0] FULL_LOAD = 24'(CLOCKS_PER_BAUD - 1);

    // o_wr / o_frame_err are single-cycle strobes with no back-pressure: the
    // consumer must take o_data on the cycle o_wr is high (o_data is held after).
    logic        rx_m;
    logic        rx_s;
    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  data_q, data_d;
    logic        wr_q, wr_d;
    logic        ferr_q, ferr_d;
    logic        brk_q, brk_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= i_uart_rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 24'd0;
            idx_q   <= 3'd0;
            sh_q    <= 8'h00;
            data_q  <= 8'h00;
            wr_q    <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        ferr_d  = 1'b0;
        brk_d   = brk_q;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                // Middle of the start bit: a high line here was only a glitch.
                if (cnt_q == 24'd0) begin
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                        cnt_d   = FULL_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            DATA: begin
                if (cnt_q == 24'd0) begin
                    sh_d  = {rx_s, sh_q[7:1]};
                    cnt_d = FULL_LOAD;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            STOP: begin
                if (cnt_q == 24'd0) begin
                    if (rx_s) begin
                        data_d  = sh_q;
                        wr_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // All-zero byte plus low stop bit means the line is held low.
                        ferr_d  = 1'b1;
                        brk_d   = (sh_q == 8'h00);
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                    brk_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_wr        = wr_q;
    assign o_data      = data_q;
    assign o_frame_err = ferr_q;
    assign o_break     = brk_q;
    assign o_state     = state_q;

endmodule
